// File: rtl/seg7_pkg.sv
// Shared types and the active-low 7-segment decode table for the press
// counter display.
package seg7_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Bit order is gfedcba, so seg[0] drives CA and seg[6] drives CG.
    function automatic logic [6:0] bcd_to_seg(input bcd_digit_t digit);
        logic [6:0] pattern;
        case (digit)
            4'd0:    pattern = 7'b1000000;
            4'd1:    pattern = 7'b1111001;
            4'd2:    pattern = 7'b0100100;
            4'd3:    pattern = 7'b0110000;
            4'd4:    pattern = 7'b0011001;
            4'd5:    pattern = 7'b0010010;
            4'd6:    pattern = 7'b0000010;
            4'd7:    pattern = 7'b1111000;
            4'd8:    pattern = 7'b0000000;
            4'd9:    pattern = 7'b0010000;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear and a sticky overflow
// flag that sets when the all-9s value wraps to zero.
module bcd_counter
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inc,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    overflow
);

    logic [4*NUM_DIGITS-1:0] count_inc;
    logic                    wrap;

    // NOTE: every variable gets a default at the top of always_comb so no
    // path leaves it unassigned; that is what keeps a latch from being inferred.
    always_comb begin
        logic       carry;
        bcd_digit_t digit;
        carry     = 1'b1;
        digit     = '0;
        count_inc = count;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit = count[4*i +: 4];
            if (carry) begin
                if (digit == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = digit + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
        wrap = carry;
    end

    // NOTE: rst_n is sampled only on the clock edge (synchronous reset), and
    // state is updated with non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (inc) begin
            count <= count_inc;
            if (wrap) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_press_counter.sv
// Button-press counter driving a multiplexed active-low 7-segment display;
// each digit slot opens with a short all-off dead time to prevent ghosting.
module seg7_press_counter
    import seg7_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = 100_000_000,
    parameter int SLOT_HZ       = 1000,
    parameter int NUM_DIGITS    = 8,
    parameter int BLANK_CYCLES  = 4,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inc_pulse,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] count_bcd,
    output logic                    overflow,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int SLOT_CYCLES = CLK_FREQ_HZ / SLOT_HZ;
    localparam int CNT_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    if ((CLK_FREQ_HZ % SLOT_HZ) != 0 || SLOT_CYCLES <= BLANK_CYCLES ||
        BLANK_CYCLES < 1 || NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_params
        $error("seg7_press_counter: illegal SLOT/BLANK/NUM_DIGITS parameters");
    end

    bcd_counter #(
        .NUM_DIGITS(NUM_DIGITS)
    ) u_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (inc_pulse),
        .clr      (clr),
        .count    (count_bcd),
        .overflow (overflow)
    );

    scan_state_t            state, state_next;
    logic [CNT_W-1:0]       slot_cnt, slot_next;
    logic [IDX_W-1:0]       idx, idx_next;
    logic [6:0]             seg_next;
    logic [NUM_DIGITS-1:0]  an_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= BLANK;
            slot_cnt <= '0;
            idx      <= '0;
            an       <= '1;
            seg      <= SEG_BLANK;
        end else begin
            state    <= state_next;
            slot_cnt <= slot_next;
            idx      <= idx_next;
            an       <= an_next;
            seg      <= seg_next;
        end
    end

    always_comb begin
        state_next = state;
        slot_next  = slot_cnt + 1'b1;
        idx_next   = idx;
        if (slot_cnt == SLOT_LAST) begin
            slot_next  = '0;
            state_next = BLANK;
            idx_next   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else if (state == BLANK && slot_cnt == BLANK_LAST) begin
            state_next = DRIVE;
        end
    end

    // Outputs are decoded from the next state so the pins are registered yet
    // still line up with the state register cycle for cycle.
    always_comb begin
        bcd_digit_t digit;
        logic       upper_nonzero;
        digit         = '0;
        upper_nonzero = 1'b0;
        an_next       = '1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j == int'(idx_next)) begin
                digit      = count_bcd[4*j +: 4];
                an_next[j] = (state_next != DRIVE);
            end
            if (j >= int'(idx_next) && count_bcd[4*j +: 4] != 4'd0) begin
                upper_nonzero = 1'b1;
            end
        end
        seg_next = SEG_BLANK;
        if (state_next == DRIVE) begin
            if (BLANK_LEADING != 0 && idx_next != '0 && !upper_nonzero) begin
                seg_next = SEG_BLANK;
            end else begin
                seg_next = bcd_to_seg(digit);
            end
        end
    end

    assign dp = 1'b1;

endmodule

// File: doc/seg7_press_counter.md
# seg7_press_counter

Counts single-cycle button-press pulses in an 8-digit BCD register and drives the board's multiplexed, active-low 7-segment display with the current count. It sits directly downstream of the button debounce / edge-detect chain in the top level. Its `inc_pulse` input takes the edge detector's one-cycle output. Its `seg`, `dp` and `an` outputs go straight to the CA..CG, DP and AN pins.

## Interface
- CLK_FREQ_HZ, 100_000_000, system clock frequency.
- SLOT_HZ, 1000, digit-slot rate. SLOT_CYCLES = CLK_FREQ_HZ/SLOT_HZ. It must be an integer greater than BLANK_CYCLES; elaboration fails otherwise.
- NUM_DIGITS, 8, number of BCD digits and anodes (1..8).
- BLANK_CYCLES, 4, anti-ghosting dead time at the start of each slot.
- BLANK_LEADING, 1, when 1, suppresses leading zeros.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; synchronous, active-low.
- inc_pulse  in  1  increment request; one cycle per press.
- clr  in  1  synchronous clear of the count and overflow.
- count_bcd  out  4*NUM_DIGITS  current count; digit 0 in bits [3:0].
- overflow  out  1  sticky; set on wrap from all-9s.
- seg  out  7  segment cathodes, active-low; seg[0]=CA … seg[6]=CG.
- dp  out  1  decimal point, active-low; held 1 (off).
- an  out  NUM_DIGITS  anodes, active-low; an[0] = rightmost digit.

## Operation
Counter:
- Increments by 1 in BCD on `inc_pulse` when `clr`=0. Each digit holds 0..9 and carries into the next.
- At the all-9s value, an increment wraps the count to 0 and sets `overflow`.
- `clr` forces the count to 0 and `overflow` to 0, and takes priority over a simultaneous `inc_pulse`, which is dropped.
- Back-to-back `inc_pulse` (every cycle) increments every cycle.

Scan FSM (states BLANK, DRIVE; digit index `idx` in 0..NUM_DIGITS-1; slot counter `slot_cnt` in 0..SLOT_CYCLES-1):
- BLANK: `an` is all ones and `seg` = 7'h7F. After BLANK_CYCLES cycles, go to DRIVE.
- DRIVE: `an[idx]`=0 and all other anode bits are 1. `seg` = decode(digit idx of `count_bcd`).
- When `slot_cnt` = SLOT_CYCLES-1: `slot_cnt` goes to 0, `idx` goes to (idx+1) mod NUM_DIGITS, and the state goes to BLANK.
- Count changes during DRIVE show on the next cycle; there is no frame snapshot.
- Decode, active-low gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Leading blanking: with BLANK_LEADING=1, digit i>0 shows `seg`=7'h7F when it and every digit above it are 0. Its anode is still driven. Digit 0 is never blanked.

Reset (`rst_n`=0 at a rising edge), outputs after that edge:
- `count_bcd`=0, `overflow`=0.
- `an`=all ones, `seg`=7'h7F, `dp`=1.
- State=BLANK, `idx`=0, `slot_cnt`=0.

Reset asserted mid-slot or mid-increment discards all state; there is no partial update.

## Timing
- `inc_pulse`/`clr` sampled at edge N → `count_bcd`/`overflow` updated after edge N. Visible on `seg` one cycle later, if that digit is in DRIVE.
- All outputs are registered; there is no combinational path from input to pin.
- Slot length is exactly SLOT_CYCLES cycles: BLANK_CYCLES of BLANK, then SLOT_CYCLES-BLANK_CYCLES of DRIVE.
- The first DRIVE of digit 0 starts BLANK_CYCLES cycles after reset release.
- Frame period = NUM_DIGITS*SLOT_CYCLES (800,000 cycles = 125 Hz at the defaults).

## Structure
- Package `seg7_pkg`:
  - `bcd_digit_t` (logic [3:0])
  - `SEG_BLANK` = 7'h7F
  - `bcd_to_seg()` decode function
  - scan state enum `scan_state_t` {BLANK, DRIVE}
- Sub-module `bcd_counter` (params NUM_DIGITS; ports clk, rst_n, inc, clr, count, overflow) holds the carry chain. The top instantiates it and implements the scan FSM.

## Test plan
Bench parameters: CLK_FREQ_HZ=800, SLOT_HZ=100, BLANK_CYCLES=2, NUM_DIGITS=8.
- Reset → `an`=8'hFF and `seg`=7'h7F immediately. 2 cycles after release, `an`=8'hFE and `seg`=7'b1000000 ("0").
- 12 single pulses → `count_bcd`=32'h00000012. In slot 0, `seg`=7'b0100100; in slot 1, `seg`=7'b1111001. Slots 2..7 show `seg`=7'h7F with their `an` bit low.
- Preload 99,999,998 via 99,999,998 back-to-back pulses (or a forced bench shortcut of the count), then 2 pulses:
  - after the 1st: `count_bcd`=32'h99999999, `overflow`=0;
  - after the 2nd: `count_bcd`=0, `overflow`=1.
- `clr` and `inc_pulse` asserted in the same cycle with count 5 → count 0, `overflow` 0.
- Over 64 cycles: each `an` bit is low for exactly 6 cycles per 8-cycle slot, and `an` is all ones for 2 cycles at every slot boundary.
- `rst_n` low for 1 cycle mid-DRIVE of digit 3 with count 42 → next cycle: count 0, `an`=8'hFF, `idx` restarts at 0.
